// File: rtl/w0rm_peripheral_bus_master_if.sv
// Core-side request/response and peripheral-bus signals of the bus master.
// The master modport is the block's view; slave is the core/peripheral side.
interface w0rm_peripheral_bus_master_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  logic                  core_valid_i;
  logic                  core_write_i;
  logic [ADDR_WIDTH-1:0] core_addr_i;
  logic [DATA_WIDTH-1:0] core_data_i;
  logic                  core_ready_o;
  logic                  core_resp_valid_o;
  logic [DATA_WIDTH-1:0] core_resp_data_o;
  logic                  core_resp_error_o;
  logic                  bus_req_valid_o;
  logic                  bus_req_write_o;
  logic [ADDR_WIDTH-1:0] bus_req_addr_o;
  logic [DATA_WIDTH-1:0] bus_req_data_o;
  logic                  bus_resp_valid_i;
  logic [DATA_WIDTH-1:0] bus_resp_data_i;

  modport master (
    input  core_valid_i, core_write_i, core_addr_i, core_data_i,
    input  bus_resp_valid_i, bus_resp_data_i,
    output core_ready_o, core_resp_valid_o, core_resp_data_o, core_resp_error_o,
    output bus_req_valid_o, bus_req_write_o, bus_req_addr_o, bus_req_data_o
  );

  modport slave (
    output core_valid_i, core_write_i, core_addr_i, core_data_i,
    output bus_resp_valid_i, bus_resp_data_i,
    input  core_ready_o, core_resp_valid_o, core_resp_data_o, core_resp_error_o,
    input  bus_req_valid_o, bus_req_write_o, bus_req_addr_o, bus_req_data_o
  );
endinterface

// File: rtl/w0rm_peripheral_bus_master.sv
// Single-outstanding peripheral bus master: IDLE -> REQ (one-cycle strobe) -> WAIT for merged response.
// Define W0RM_BUS_MASTER_TIMEOUT_EN to abort with an error after TIMEOUT_CYCLES wait cycles.
module w0rm_peripheral_bus_master #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input logic                          bus_clock,
  input logic                          bus_reset,
  w0rm_peripheral_bus_master_if.master bus_if
);

  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be within 2..255");
  end

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_e;

  state_e                state_q, state_d;
  logic                  wr_q, wr_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  resp_vld_q, resp_vld_d;
  logic [DATA_WIDTH-1:0] resp_data_q, resp_data_d;
`ifdef W0RM_BUS_MASTER_TIMEOUT_EN
  logic                  resp_err_q, resp_err_d;
  logic [7:0]            cnt_q, cnt_d;
`endif

  always_ff @(posedge bus_clock) begin
    if (bus_reset) begin
      state_q     <= IDLE;
      wr_q        <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
      resp_vld_q  <= 1'b0;
      resp_data_q <= '0;
`ifdef W0RM_BUS_MASTER_TIMEOUT_EN
      resp_err_q  <= 1'b0;
      cnt_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      wr_q        <= wr_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      resp_vld_q  <= resp_vld_d;
      resp_data_q <= resp_data_d;
`ifdef W0RM_BUS_MASTER_TIMEOUT_EN
      resp_err_q  <= resp_err_d;
      cnt_q       <= cnt_d;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    wr_d        = wr_q;
    addr_d      = addr_q;
    data_d      = data_q;
    resp_vld_d  = 1'b0;
    resp_data_d = resp_data_q;
`ifdef W0RM_BUS_MASTER_TIMEOUT_EN
    resp_err_d  = 1'b0;
    cnt_d       = cnt_q;
`endif
    unique case (state_q)
      IDLE: begin
        // Responses arriving here are strays and are deliberately not looked at.
        if (bus_if.core_valid_i) begin
          wr_d    = bus_if.core_write_i;
          addr_d  = bus_if.core_addr_i;
          data_d  = bus_if.core_data_i;
          state_d = REQ;
`ifdef W0RM_BUS_MASTER_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      REQ, WAIT: begin
        // A response on the timeout edge wins, so it is tested first.
        if (bus_if.bus_resp_valid_i) begin
          resp_vld_d  = 1'b1;
          resp_data_d = bus_if.bus_resp_data_i;
          state_d     = IDLE;
        end
`ifdef W0RM_BUS_MASTER_TIMEOUT_EN
        else if (cnt_q == 8'(TIMEOUT_CYCLES)) begin
          resp_vld_d  = 1'b1;
          resp_err_d  = 1'b1;
          resp_data_d = '0;
          state_d     = IDLE;
        end else begin
          cnt_d   = cnt_q + 8'd1;
          state_d = WAIT;
        end
`else
        else begin
          state_d = WAIT;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus_if.core_ready_o      = (state_q == IDLE);
  assign bus_if.core_resp_valid_o = resp_vld_q;
  assign bus_if.core_resp_data_o  = resp_data_q;
`ifdef W0RM_BUS_MASTER_TIMEOUT_EN
  assign bus_if.core_resp_error_o = resp_err_q;
`else
  assign bus_if.core_resp_error_o = 1'b0;
`endif

  // Captured request is only visible on the bus while a transaction is open.
  assign bus_if.bus_req_valid_o = (state_q == REQ);
  assign bus_if.bus_req_write_o = (state_q != IDLE) & wr_q;
  assign bus_if.bus_req_addr_o  = (state_q != IDLE) ? addr_q : '0;
  assign bus_if.bus_req_data_o  = (state_q != IDLE) ? data_q : '0;

endmodule

// File: tb/tb_w0rm_peripheral_bus_master.sv
// Table-driven plus randomized self-checking bench for w0rm_peripheral_bus_master.
// Expected responses come from a transaction-level latency/timeout model.
module tb_w0rm_peripheral_bus_master;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int TO = 16;
`ifdef W0RM_BUS_MASTER_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  w0rm_peripheral_bus_master_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bif();

  w0rm_peripheral_bus_master #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)) dut (
    .bus_clock(clk),
    .bus_reset(rst),
    .bus_if   (bif)
  );

  int checks = 0;
  int passes = 0;
  int cyc    = 0;
  logic [DW-1:0] last_rd = '0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic          wr;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    int            lat;
    logic [DW-1:0] rd;
    int            ecyc;
    logic [DW-1:0] edata;
    logic          eerr;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input bit ok, input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (ok) passes++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
  endtask

  // lat = cycles after the bus_req_valid_o cycle at which the response strobe is driven.
  // Response appears lat+1 cycles after the strobe, unless the timeout fires first.
  function automatic void model(input int lat, input logic [DW-1:0] rd,
                                output int ecyc, output logic [DW-1:0] edata, output logic eerr);
    if (TO_EN && lat > TO) begin
      ecyc = TO + 1; edata = '0; eerr = 1'b1;
    end else begin
      ecyc = lat + 1; edata = rd; eerr = 1'b0;
    end
  endfunction

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic run_txn(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input int lat, input logic [DW-1:0] rd, input int ecyc,
                         input logic [DW-1:0] edata, input logic eerr, output int pcyc);
    int c, got;
    bit hold_ok, extra;
    chk(bif.core_ready_o === 1'b1, "ready_before_req", bif.core_ready_o, 1);
    bif.core_valid_i = 1'b1; bif.core_write_i = wr; bif.core_addr_i = a; bif.core_data_i = d;
    @(negedge clk);
    pcyc = cyc;
    bif.core_valid_i = 1'b0;
    bif.core_write_i = 1'($urandom); bif.core_addr_i = $urandom; bif.core_data_i = $urandom;
    chk(bif.bus_req_valid_o === 1'b1 && bif.bus_req_addr_o === a && bif.bus_req_write_o === wr &&
        bif.bus_req_data_o === d && bif.core_ready_o === 1'b0,
        "bus_req_issue", {bif.bus_req_valid_o, bif.bus_req_write_o, bif.bus_req_addr_o}, {1'b1, wr, a});
    chk(bif.core_resp_valid_o === 1'b0 && bif.core_resp_data_o === last_rd,
        "resp_data_hold", bif.core_resp_data_o, last_rd);
    c = 0; got = -1; hold_ok = 1'b1; extra = 1'b0;
    while (got < 0 && c <= ecyc + 2) begin
      bif.bus_resp_valid_i = (c == lat);
      bif.bus_resp_data_i  = (c == lat) ? rd : DW'($urandom);
      @(negedge clk);
      c++;
      if (bif.core_resp_valid_o === 1'b1) got = c;
      else begin
        if (bif.bus_req_valid_o !== 1'b0) extra = 1'b1;
        if (bif.bus_req_addr_o !== a || bif.bus_req_write_o !== wr || bif.bus_req_data_o !== d ||
            bif.core_ready_o !== 1'b0) hold_ok = 1'b0;
      end
    end
    bif.bus_resp_valid_i = 1'b0;
    chk(got == ecyc, "resp_latency", got, ecyc);
    chk(bif.core_resp_data_o === edata && bif.core_resp_error_o === eerr && bif.core_ready_o === 1'b1 &&
        bif.bus_req_valid_o === 1'b0 && bif.bus_req_addr_o === '0 && bif.bus_req_data_o === '0 &&
        bif.bus_req_write_o === 1'b0,
        "resp_value", {bif.core_resp_error_o, bif.core_resp_data_o}, {eerr, edata});
    chk(hold_ok && !extra, "req_hold_no_dup", {hold_ok, extra}, 2'b10);
    last_rd = edata;
  endtask

  task automatic run_model(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                           input int lat, input logic [DW-1:0] rd, output int pcyc);
    int ec; logic [DW-1:0] ed; logic ee;
    model(lat, rd, ec, ed, ee);
    run_txn(wr, a, d, lat, rd, ec, ed, ee, pcyc);
  endtask

  task automatic chk_reset_outputs(input string nm);
    chk(bif.core_ready_o === 1'b1 && bif.core_resp_valid_o === 1'b0 && bif.core_resp_data_o === '0 &&
        bif.core_resp_error_o === 1'b0 && bif.bus_req_valid_o === 1'b0 && bif.bus_req_write_o === 1'b0 &&
        bif.bus_req_addr_o === '0 && bif.bus_req_data_o === '0,
        nm, {bif.core_ready_o, bif.core_resp_valid_o, bif.bus_req_valid_o, bif.core_resp_data_o}, 36'h4_0000_0000);
  endtask

  initial begin
    int p0, p1, p2, p3;
    vecs[0] = '{1'b0, 32'h0000_0010, 32'h0,         2,  32'hDEAD_BEEF, 3,  32'hDEAD_BEEF, 1'b0};
    vecs[1] = '{1'b1, 32'h0000_0020, 32'h0000_5A5A, 0,  32'h0000_00A5, 1,  32'h0000_00A5, 1'b0};
    vecs[2] = '{1'b0, 32'hFFFF_FFFC, 32'h0,         5,  32'h0000_0000, 6,  32'h0000_0000, 1'b0};
    vecs[3] = '{1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1,  32'h1357_9BDF, 2,  32'h1357_9BDF, 1'b0};
    vecs[4] = '{1'b0, 32'h0000_0044, 32'h0,         16, 32'hCAFE_F00D, 17, 32'hCAFE_F00D, 1'b0};

    bif.core_valid_i = 1'b0; bif.core_write_i = 1'b0; bif.core_addr_i = '0; bif.core_data_i = '0;
    bif.bus_resp_valid_i = 1'b0; bif.bus_resp_data_i = '0;

    // Reset, with a request presented in the last reset cycle that must be dropped.
    idle(2);
    chk_reset_outputs("reset_state");
    bif.core_valid_i = 1'b1; bif.core_addr_i = 32'h99;
    @(negedge clk);
    rst = 1'b0; bif.core_valid_i = 1'b0;
    @(negedge clk);
    chk_reset_outputs("req_during_reset_dropped");

    foreach (vecs[i])
      run_txn(vecs[i].wr, vecs[i].a, vecs[i].d, vecs[i].lat, vecs[i].rd,
              vecs[i].ecyc, vecs[i].edata, vecs[i].eerr, p0);
    idle(1);

    // Back-to-back: strobe spacing = (strobe-to-response latency lat+1) + 1.
    run_model(1'b0, 32'h100, 32'h0, 1, 32'h1111_1111, p0);
    run_model(1'b1, 32'h104, 32'hAB, 3, 32'h2222_2222, p1);
    run_model(1'b0, 32'h108, 32'h0, 0, 32'h3333_3333, p2);
    run_model(1'b1, 32'h10C, 32'hCD, 2, 32'h4444_4444, p3);
    chk(p1 - p0 == 3, "b2b_spacing_0", p1 - p0, 3);
    chk(p2 - p1 == 5, "b2b_spacing_1", p2 - p1, 5);
    chk(p3 - p2 == 2, "b2b_spacing_2", p3 - p2, 2);

    // Stray response in IDLE.
    idle(1);
    bif.bus_resp_valid_i = 1'b1; bif.bus_resp_data_i = 32'h1234;
    @(negedge clk);
    bif.bus_resp_valid_i = 1'b0;
    @(negedge clk);
    chk(bif.core_resp_valid_o === 1'b0 && bif.core_resp_data_o === last_rd && bif.core_ready_o === 1'b1 &&
        bif.bus_req_valid_o === 1'b0, "stray_resp_ignored", bif.core_resp_data_o, last_rd);

    // Timeout boundary (16 = response wins the shared edge, 17 = timeout if enabled), then a late response.
    run_model(1'b0, 32'h200, 32'h0, 16, 32'h5555_AAAA, p0);
    run_model(1'b0, 32'h204, 32'h0, 17, 32'h6666_BBBB, p0);
    run_model(1'b1, 32'h208, 32'h77, 40, 32'h7777_CCCC, p0);
    bif.bus_resp_valid_i = 1'b1; bif.bus_resp_data_i = 32'hBAD0_0000;
    @(negedge clk);
    bif.bus_resp_valid_i = 1'b0;
    @(negedge clk);
    chk(bif.core_resp_valid_o === 1'b0 && bif.core_resp_data_o === last_rd && bif.core_ready_o === 1'b1,
        "late_resp_ignored", bif.core_resp_data_o, last_rd);

    // Reset while waiting, response arriving right after reset.
    bif.core_valid_i = 1'b1; bif.core_write_i = 1'b0; bif.core_addr_i = 32'h300;
    @(negedge clk);
    bif.core_valid_i = 1'b0;
    idle(2);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bif.bus_resp_valid_i = 1'b1; bif.bus_resp_data_i = 32'hFEED_FACE;
    @(negedge clk);
    bif.bus_resp_valid_i = 1'b0;
    chk_reset_outputs("reset_in_wait");
    @(negedge clk);
    chk_reset_outputs("reset_in_wait_no_pulse");
    last_rd = '0;
    run_model(1'b0, 32'h304, 32'h0, 2, 32'h0BAD_CAFE, p0);

    // Randomized transactions with random idle gaps.
    for (int i = 0; i < 30; i++) begin
      idle($urandom_range(0, 2));
      run_model(1'($urandom), $urandom, $urandom, $urandom_range(0, 24), $urandom, p0);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule
